// File: rtl/wb_commit_sched.sv
// Writeback commit scheduler for the shared DCache commit/flush interface.
// Committed stores from the dual-issue writeback stage are counted as credits.
// The credits are drained to DCache one per handshake. On any flush cause,
// all pending commits drain before a DCache flush is requested, and
// writeback is held off until the flush is acknowledged.
module wb_commit_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic [1:0]       lane_valid_i,
  input  logic [1:0]       lane_store_i,
  input  logic [1:0]       lane_excp_i,
  input  logic [1:0]       lane_redirect_i,
  input  logic [1:0]       lane_refetch_i,
  output logic             dcache_commit_valid_o,
  input  logic             dcache_commit_ready_i,
  output logic             dcache_flush_o,
  input  logic             dcache_flush_ack_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] pending_cnt_o,
  output logic             busy_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   FULL_WIDE = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_TH  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ovf_now;

  logic             idle;
  logic             take0, take1;
  logic             cause0, cause1;
  logic             kill1;
  logic             st0, st1;
  logic             flush_cause;
  logic             deq;
  logic [CNT_W:0]   cnt_sum;

  // Lane qualification: lane 0 is older, so a cause on lane 0 squashes lane 1.
  always_comb begin
    idle        = (state == S_IDLE);
    take0       = advance_i & lane_valid_i[0] & idle;
    take1       = advance_i & lane_valid_i[1] & idle;
    cause0      = lane_excp_i[0] | lane_redirect_i[0] | lane_refetch_i[0];
    cause1      = lane_excp_i[1] | lane_redirect_i[1] | lane_refetch_i[1];
    kill1       = take0 & cause0;
    // A redirect or refetch still lets the store commit; only an exception blocks it.
    st0         = take0 & lane_store_i[0] & ~lane_excp_i[0];
    st1         = take1 & ~kill1 & lane_store_i[1] & ~lane_excp_i[1];
    flush_cause = (take0 & cause0) | (take1 & ~kill1 & cause1);
  end

  // Credit counter arithmetic: enqueue and dequeue in one cycle both apply.
  always_comb begin
    dcache_commit_valid_o = (cnt != '0);
    deq                   = dcache_commit_valid_o & dcache_commit_ready_i;
    // One spare bit so that an over-subscribed enqueue is visible before saturation.
    cnt_sum = {1'b0, cnt} + (CNT_W + 1)'(st0) + (CNT_W + 1)'(st1)
            - (CNT_W + 1)'(deq);
    ovf_now  = (cnt_sum > FULL_WIDE);
    cnt_next = ovf_now ? FULL : cnt_sum[CNT_W-1:0];
  end

  // Next-state decode for the drain-then-flush sequence.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:  if (flush_cause) state_next = S_DRAIN;
      S_DRAIN: if ((cnt == '0) || ((cnt == ONE) && deq)) state_next = S_FLUSH;
      S_FLUSH: if (dcache_flush_ack_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, credit count and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      cnt   <= cnt_next;
      if (ovf_now) overflow_o <= 1'b1;
    end
  end

  // Output decode from the registered state and count.
  always_comb begin
    dcache_flush_o = (state == S_FLUSH);
    busy_o         = (state != S_IDLE);
    stall_o        = (cnt >= STALL_TH) | (state != S_IDLE);
    pending_cnt_o  = cnt;
  end

endmodule

// File: tb/tb_wb_commit_sched.sv
// Directed testbench for wb_commit_sched (DEPTH=4).
module tb_wb_commit_sched;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             advance;
  logic [1:0]       lane_valid;
  logic [1:0]       lane_store;
  logic [1:0]       lane_excp;
  logic [1:0]       lane_redirect;
  logic [1:0]       lane_refetch;
  logic             commit_valid;
  logic             commit_ready;
  logic             flush;
  logic             flush_ack;
  logic             stall;
  logic [CNT_W-1:0] pending_cnt;
  logic             busy;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  wb_commit_sched #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .advance_i             (advance),
    .lane_valid_i          (lane_valid),
    .lane_store_i          (lane_store),
    .lane_excp_i           (lane_excp),
    .lane_redirect_i       (lane_redirect),
    .lane_refetch_i        (lane_refetch),
    .dcache_commit_valid_o (commit_valid),
    .dcache_commit_ready_i (commit_ready),
    .dcache_flush_o        (flush),
    .dcache_flush_ack_i    (flush_ack),
    .stall_o               (stall),
    .pending_cnt_o         (pending_cnt),
    .busy_o                (busy),
    .overflow_o            (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic adv, input logic [1:0] valid, input logic [1:0] store,
                       input logic [1:0] excp, input logic [1:0] redir, input logic [1:0] refetch);
    advance       = adv;
    lane_valid    = valid;
    lane_store    = store;
    lane_excp     = excp;
    lane_redirect = redir;
    lane_refetch  = refetch;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  // Advance one clock, then settle just after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".commit_valid"}, 32'(commit_valid), 32'd0);
    check({tag, ".flush"},        32'(flush),        32'd0);
    check({tag, ".stall"},        32'(stall),        32'd0);
    check({tag, ".busy"},         32'(busy),         32'd0);
    check({tag, ".cnt"},          32'(pending_cnt),  32'd0);
    check({tag, ".overflow"},     32'(overflow),     32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    commit_ready = 1'b0;
    flush_ack    = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    #11;
    rst_n = 1'b1;

    // Dual store, always ready: 0 -> 2 -> 1 -> 0.
    commit_ready = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tick();
    idle_inputs();
    check("dual.cnt2",   32'(pending_cnt),  32'd2);
    check("dual.valid2", 32'(commit_valid), 32'd1);
    tick();
    check("dual.cnt1",   32'(pending_cnt),  32'd1);
    check("dual.valid1", 32'(commit_valid), 32'd1);
    tick();
    check("dual.cnt0",   32'(pending_cnt),  32'd0);
    check("dual.valid0", 32'(commit_valid), 32'd0);
    check("dual.flush",  32'(flush),        32'd0);
    check("dual.busy",   32'(busy),         32'd0);

    // Backpressure: three single stores, then an over-subscribed dual store.
    commit_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    tick();
    check("bp.cnt2",    32'(pending_cnt), 32'd2);
    check("bp.stall2",  32'(stall),       32'd0);
    tick();
    check("bp.cnt3",    32'(pending_cnt), 32'd3);
    check("bp.stall3",  32'(stall),       32'd1);
    check("bp.ovf3",    32'(overflow),    32'd0);
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tick();
    idle_inputs();
    check("bp.cnt_sat", 32'(pending_cnt), 32'd4);
    check("bp.ovf",     32'(overflow),    32'd1);
    tick();
    check("bp.cnt_hold", 32'(pending_cnt), 32'd4);
    commit_ready = 1'b1;
    repeat (4) tick();
    check("bp.drained",    32'(pending_cnt), 32'd0);
    check("bp.ovf_sticky", 32'(overflow),    32'd1);
    check("bp.stall_rel",  32'(stall),       32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("bp.ovf_reset", 32'(overflow), 32'd0);
    #2;
    rst_n = 1'b1;

    // Lane-0 exception kills the lane-1 store; flush follows two cycles later.
    drive(1'b1, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00);
    tick();
    idle_inputs();
    check("exc.cnt",    32'(pending_cnt), 32'd0);
    check("exc.busy",   32'(busy),        32'd1);
    check("exc.stall",  32'(stall),       32'd1);
    check("exc.flush0", 32'(flush),       32'd0);
    tick();
    check("exc.flush1",  32'(flush),        32'd1);
    check("exc.cvalid",  32'(commit_valid), 32'd0);
    tick();
    check("exc.flush_hold", 32'(flush), 32'd1);
    // Advance during FLUSH is ignored.
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tick();
    idle_inputs();
    check("flush_adv.cnt",   32'(pending_cnt), 32'd0);
    check("flush_adv.flush", 32'(flush),       32'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("exc.ack_flush", 32'(flush), 32'd0);
    check("exc.ack_busy",  32'(busy),  32'd0);
    check("exc.ack_stall", 32'(stall), 32'd0);
    // A stray ack in IDLE does nothing.
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("stray_ack.busy", 32'(busy), 32'd0);

    // Lane-1 redirect store plus lane-0 store: both commit before the flush.
    commit_ready = 1'b0;
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00);
    tick();
    idle_inputs();
    check("redir.cnt2",  32'(pending_cnt), 32'd2);
    check("redir.busy",  32'(busy),        32'd1);
    tick();
    check("redir.hold_cnt",   32'(pending_cnt), 32'd2);
    check("redir.hold_flush", 32'(flush),       32'd0);
    commit_ready = 1'b1;
    tick();
    check("redir.cnt1",   32'(pending_cnt), 32'd1);
    check("redir.flush1", 32'(flush),       32'd0);
    tick();
    check("redir.cnt0",   32'(pending_cnt), 32'd0);
    check("redir.flush",  32'(flush),       32'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("redir.idle", 32'(busy), 32'd0);

    // Lane-1 store with exception does not commit; lane-0 store does.
    commit_ready = 1'b0;
    drive(1'b1, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00);
    tick();
    idle_inputs();
    check("exc1.cnt",  32'(pending_cnt), 32'd1);
    check("exc1.busy", 32'(busy),        32'd1);
    commit_ready = 1'b1;
    tick();
    check("exc1.flush", 32'(flush), 32'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;

    // Async reset mid-DRAIN with two pending commits.
    commit_ready = 1'b0;
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10);
    tick();
    idle_inputs();
    check("rst.pre_cnt",  32'(pending_cnt), 32'd2);
    check("rst.pre_busy", 32'(busy),        32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst.mid");
    #2;
    rst_n = 1'b1;
    tick();
    check("rst.after_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
